iol_soft_gearbox: RTL and testbench
===================================

Name: iol_soft_gearbox

Overview:
- Parametrised multi-channel soft I/O gearbox: serialises GEAR-bit parallel words onto CHANNELS pins and deserialises CHANNELS serial inputs into GEAR-bit words, all on one fabric clock.
- Successor to the fixed X1/X2 IDDR/ODDR fuzz structures; adds arbitrary gear ratio, per-channel tristate and per-channel training/bitslip word alignment.
- Sits between fabric logic and PIO pins in the IOL timing fuzzer designs.

Parameters:
- CHANNELS, 4, number of serial pins per direction (1..16)
- GEAR, 4, bits per parallel word (2..8)
- TRAIN_PATTERN, 8'hB4, training word; low GEAR bits used; must be rotation-unique
- LOCK_COUNT, 8, consecutive matching words required for lock (1..255)

Ports:
- ignore_clk  in  1  sole clock, rising edge
- ignore_rst_n  in  1  reset, synchronous, active-low
- tx_data  in  CHANNELS*GEAR  word for channel c at [c*GEAR +: GEAR], bit 0 sent first
- tx_oe  in  CHANNELS  output enable per channel, sampled with tx_data
- tx_valid  in  1  tx_data/tx_oe valid
- tx_ready  out  1  gearbox accepts a word this cycle
- ser_q  out  CHANNELS  serial data to pins
- ser_t  out  CHANNELS  tristate control, 1 = high-Z
- ser_d  in  CHANNELS  serial data from pins
- rx_data  out  CHANNELS*GEAR  deserialised words, bit 0 = oldest bit
- rx_valid  out  CHANNELS  per-channel word strobe
- train_en  in  1  enables the training FSMs
- rx_locked  out  CHANNELS  per-channel alignment lock

Behaviour:
- Reset (ignore_rst_n=0 at an edge): ser_q=0, ser_t=all 1, rx_data=0, rx_valid=0, rx_locked=0, all counters 0, FSMs to HUNT, tx shifter empty. tx_ready is combinational from state and reads 1 from the first cycle after reset.
- Reset mid-word: word in flight is discarded; ser_t goes high-Z at that edge.
- TX:
  - tx_ready = shifter empty OR tx_phase==GEAR-1. Transfer occurs on tx_valid && tx_ready.
  - If a word is accepted at edge N, bit k appears on ser_q at edge N+1+k, and ser_t[c] = ~tx_oe[c] over the same span.
  - Back-to-back words are gapless; tx_ready is high one cycle in every GEAR while streaming.
  - Underflow: no transfer at phase GEAR-1 -> shifter empties; next cycle ser_q=0, ser_t=all 1.
  - tx_valid while tx_ready=0 is ignored; no data is lost or duplicated.
- RX, per channel, independent:
  - ser_d is registered, then shifted in MSB-first so the oldest bit lands at bit 0.
  - Per-channel phase counter runs 0..GEAR-1. At wrap, rx_data slice is updated and rx_valid[c] pulses for one cycle.
  - rx_valid[c] interval is GEAR cycles, or GEAR+1 when a slip occurs.
- Bitslip: a slip holds the channel phase counter for one cycle, moving the word boundary by one bit. The next word is GEAR+1 cycles later. Slip count wraps modulo GEAR implicitly.
- Training FSM, per channel; evaluated only on cycles with rx_valid[c]=1 and train_en=1; compares rx_data slice to TRAIN_PATTERN[GEAR-1:0].
  - HUNT: mismatch -> slip (counter hold next cycle), stay HUNT. Match -> CHECK, cnt=1; if LOCK_COUNT==1 go directly to LOCKED.
  - CHECK: match -> cnt+1; reaching LOCK_COUNT -> LOCKED. Mismatch -> HUNT, cnt=0, slip.
  - LOCKED: rx_locked[c]=1. Mismatch -> HUNT, rx_locked[c]=0 on the next edge, slip.
  - train_en=0: FSM and rx_locked are frozen, no slips; data path and rx_valid keep running.
  - No slip limit; HUNT cycles through boundaries indefinitely.
- Width: cnt is 8 bits, saturating at LOCK_COUNT. Phase counters are $clog2(GEAR) bits, with explicit wrap at GEAR-1 (non-power-of-2 GEAR must wrap correctly).

Test Plan:
- Reset: hold ignore_rst_n=0 for 3 edges with random inputs -> ser_t=4'hF, ser_q=0, rx_valid=0, rx_locked=0. First cycle after release: tx_ready=1.
- TX stream, GEAR=4: words ch0 = 4'hA, 4'h5, 4'hC with tx_oe=1, tx_valid held -> ser_q[0] = 0,1,0,1, 1,0,1,0, 0,0,1,1 gapless from edge N+1; ser_t[0]=0 throughout; tx_ready high every 4th cycle.
- TX underflow/tristate: one word 4'hF with tx_oe=4'b0101, then tx_valid=0 -> ser_t = 4'b1010 for 4 cycles, then ser_t=4'hF and ser_q=0.
- RX training: loopback ser_q->ser_d, TX repeating 4'h4 with a 2-bit lane skew on ch1, train_en=1 -> ch0 locks after 8 matching words; ch1 slips ≤3 times then locks; both rx_data slices = 4'h4.
- Lock loss: with the lock established, flip one bit in ch2 -> rx_locked[2]=0 one edge after that rx_valid; relocks after LOCK_COUNT clean words; other channels stay locked.
- Reset mid-operation: assert reset at tx_phase=2 while locked -> all outputs return to reset values at that edge; no residual bits appear on ser_q after release.

Source files
------------

// File: rtl/iol_soft_gearbox.sv
// iol_soft_gearbox
//   Multi-channel soft I/O gearbox running on a single fabric clock.
//   TX side: accepts one GEAR-bit word per channel and streams it out
//   LSB first on ser_q, with per-channel tristate taken from tx_oe.
//   RX side: registers each serial input, shifts it into a GEAR-bit word
//   (oldest bit at bit 0) and strobes rx_valid per channel on every word
//   boundary. A per-channel training FSM compares each word with the
//   training pattern and bit-slips the boundary until it sees LOCK_COUNT
//   consecutive matches.
//
// Ports
//   ignore_clk    in   sole clock, rising edge
//   ignore_rst_n  in   synchronous active-low reset
//   tx_data       in   CHANNELS*GEAR, channel c at [c*GEAR +: GEAR]
//   tx_oe         in   CHANNELS output enables, captured with tx_data
//   tx_valid      in   tx_data/tx_oe valid
//   tx_ready      out  word can be accepted this cycle (combinational)
//   ser_q         out  CHANNELS serial data to pins
//   ser_t         out  CHANNELS tristate controls, 1 = high-Z
//   ser_d         in   CHANNELS serial data from pins
//   rx_data       out  CHANNELS*GEAR deserialised words
//   rx_valid      out  CHANNELS word strobes
//   train_en      in   enables the training FSMs
//   rx_locked     out  CHANNELS alignment lock flags
module iol_soft_gearbox #(
  parameter int         CHANNELS      = 4,
  parameter int         GEAR          = 4,
  parameter logic [7:0] TRAIN_PATTERN = 8'hB4,
  parameter int         LOCK_COUNT    = 8
) (
  input  logic                       ignore_clk,
  input  logic                       ignore_rst_n,
  input  logic [CHANNELS*GEAR-1:0]   tx_data,
  input  logic [CHANNELS-1:0]        tx_oe,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic [CHANNELS-1:0]        ser_q,
  output logic [CHANNELS-1:0]        ser_t,
  input  logic [CHANNELS-1:0]        ser_d,
  output logic [CHANNELS*GEAR-1:0]   rx_data,
  output logic [CHANNELS-1:0]        rx_valid,
  input  logic                       train_en,
  output logic [CHANNELS-1:0]        rx_locked
);

  localparam int              PW          = $clog2(GEAR);
  localparam logic [PW-1:0]   LAST_PHASE  = PW'(GEAR - 1);
  localparam logic [GEAR-1:0] PATTERN     = TRAIN_PATTERN[GEAR-1:0];
  localparam logic [7:0]      LOCK_TARGET = 8'(LOCK_COUNT);

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } train_state_t;

  // ---------------------------------------------------------------------
  // TX path
  // ---------------------------------------------------------------------
  logic                     tx_busy;
  logic [PW-1:0]            tx_phase;
  logic [CHANNELS*GEAR-1:0] tx_shift;
  logic [CHANNELS-1:0]      tx_oe_hold;
  logic                     tx_take;

  // A new word may be loaded while the last bit of the current one is
  // being launched, which keeps back-to-back words gapless.
  assign tx_ready = ~tx_busy | (tx_phase == LAST_PHASE);
  assign tx_take  = tx_valid & tx_ready;

  // ser_q/ser_t are registered one edge behind the shifter: bit k of a
  // word loaded at edge N is launched at edge N+1+k. An empty shifter
  // drives zero and releases the pins to high-Z.
  always_ff @(posedge ignore_clk) begin
    if (!ignore_rst_n) begin
      tx_busy    <= 1'b0;
      tx_phase   <= '0;
      tx_shift   <= '0;
      tx_oe_hold <= '0;
      ser_q      <= '0;
      ser_t      <= '1;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        ser_q[c] <= tx_busy & tx_shift[c*GEAR];
        ser_t[c] <= ~(tx_busy & tx_oe_hold[c]);
      end
      if (tx_take) begin
        tx_shift   <= tx_data;
        tx_oe_hold <= tx_oe;
        tx_busy    <= 1'b1;
        tx_phase   <= '0;
      end else if (tx_busy) begin
        for (int c = 0; c < CHANNELS; c++) begin
          tx_shift[c*GEAR +: GEAR] <= {1'b0, tx_shift[c*GEAR+1 +: GEAR-1]};
        end
        if (tx_phase == LAST_PHASE) begin
          tx_busy  <= 1'b0;
          tx_phase <= '0;
        end else begin
          tx_phase <= tx_phase + PW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // RX path and training
  // ---------------------------------------------------------------------
  logic [CHANNELS-1:0]      d_reg;
  logic [CHANNELS*GEAR-1:0] rx_shift;
  logic [CHANNELS*GEAR-1:0] shift_next;
  logic [PW-1:0]            rx_phase  [CHANNELS];
  logic [7:0]               lock_cnt  [CHANNELS];
  train_state_t             state     [CHANNELS];
  logic [CHANNELS-1:0]      match;
  logic [CHANNELS-1:0]      slip_now;

  // New bits enter at the MSB so that after GEAR shifts the oldest bit
  // sits at bit 0. A slip is decided in the rx_valid cycle and takes
  // effect on the same edge by holding that channel's phase counter.
  always_comb begin
    shift_next = '0;
    match      = '0;
    slip_now   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      shift_next[c*GEAR +: GEAR] = {d_reg[c], rx_shift[c*GEAR+1 +: GEAR-1]};
      match[c]    = (rx_data[c*GEAR +: GEAR] == PATTERN);
      slip_now[c] = rx_valid[c] & train_en & ~match[c];
    end
  end

  // Deserialiser, word strobe and per-channel training FSM. Every
  // mismatch seen while training, in any state, costs one bit slip and
  // sends the channel back to HUNT; lock_cnt saturates at LOCK_COUNT.
  always_ff @(posedge ignore_clk) begin
    if (!ignore_rst_n) begin
      d_reg     <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= '0;
      rx_locked <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        rx_phase[c] <= '0;
        lock_cnt[c] <= '0;
        state[c]    <= HUNT;
      end
    end else begin
      d_reg    <= ser_d;
      rx_shift <= shift_next;
      for (int c = 0; c < CHANNELS; c++) begin
        if (rx_phase[c] == LAST_PHASE) begin
          rx_phase[c]              <= '0;
          rx_data[c*GEAR +: GEAR]  <= shift_next[c*GEAR +: GEAR];
          rx_valid[c]              <= 1'b1;
        end else begin
          rx_valid[c] <= 1'b0;
          if (!slip_now[c]) begin
            rx_phase[c] <= rx_phase[c] + PW'(1);
          end
        end

        if (rx_valid[c] && train_en) begin
          case (state[c])
            HUNT: begin
              if (match[c]) begin
                lock_cnt[c] <= 8'd1;
                if (LOCK_TARGET <= 8'd1) begin
                  state[c]     <= LOCKED;
                  rx_locked[c] <= 1'b1;
                end else begin
                  state[c] <= CHECK;
                end
              end
            end
            CHECK: begin
              if (match[c]) begin
                if (lock_cnt[c] + 8'd1 >= LOCK_TARGET) begin
                  lock_cnt[c]  <= LOCK_TARGET;
                  state[c]     <= LOCKED;
                  rx_locked[c] <= 1'b1;
                end else begin
                  lock_cnt[c] <= lock_cnt[c] + 8'd1;
                end
              end else begin
                lock_cnt[c] <= '0;
                state[c]    <= HUNT;
              end
            end
            LOCKED: begin
              if (!match[c]) begin
                lock_cnt[c]  <= '0;
                state[c]     <= HUNT;
                rx_locked[c] <= 1'b0;
              end
            end
            default: begin
              lock_cnt[c]  <= '0;
              state[c]     <= HUNT;
              rx_locked[c] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_iol_soft_gearbox.sv
// tb_iol_soft_gearbox
//   Drives iol_soft_gearbox with directed and $urandom stimulus and checks
//   every cycle against a reference model: TX is a queue of future pin
//   values, RX is a history of sampled serial bits plus a word-boundary
//   schedule and a match counter per channel.
module tb_iol_soft_gearbox;

  localparam int         CH  = 4;
  localparam int         G   = 4;
  localparam int         LC  = 8;
  localparam logic [7:0] TP  = 8'hB4;
  localparam logic [G-1:0] PAT = TP[G-1:0];

  logic              clk;
  logic              rst_n;
  logic [CH*G-1:0]   tx_data;
  logic [CH-1:0]     tx_oe;
  logic              tx_valid;
  logic              tx_ready;
  logic [CH-1:0]     ser_q;
  logic [CH-1:0]     ser_t;
  logic [CH-1:0]     ser_d;
  logic [CH*G-1:0]   rx_data;
  logic [CH-1:0]     rx_valid;
  logic              train_en;
  logic [CH-1:0]     rx_locked;

  iol_soft_gearbox #(
    .CHANNELS(CH), .GEAR(G), .TRAIN_PATTERN(TP), .LOCK_COUNT(LC)
  ) dut (
    .ignore_clk(clk), .ignore_rst_n(rst_n),
    .tx_data(tx_data), .tx_oe(tx_oe), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ser_q(ser_q), .ser_t(ser_t), .ser_d(ser_d),
    .rx_data(rx_data), .rx_valid(rx_valid), .train_en(train_en),
    .rx_locked(rx_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  int checks = 0;
  int errors = 0;

  // TX model: each entry is {ser_t, ser_q} expected after one future edge
  logic [2*CH-1:0] tx_q [$];
  logic [CH-1:0]   exp_q, exp_t;

  // RX model
  int            edge_no = 0;
  logic          hist [CH][64];
  int            next_wrap [CH];
  int            eval_edge [CH];
  bit            eval_pending [CH];
  int            m_cnt [CH];
  logic [G-1:0]  m_data [CH];
  logic [CH-1:0] m_valid, m_locked;

  bit            primed = 0;
  bit            loopback = 0;
  logic          flip2 = 1'b0;
  logic [1:0]    lag1 = '0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%0h want=%0h edge=%0d", tag, got, want, edge_no);
    end
  endtask

  task automatic modelEdge(input logic accept);
    int e;
    e = edge_no;
    if (!rst_n) begin
      tx_q.delete();
      exp_q = '0;
      exp_t = '1;
      m_valid = '0;
      m_locked = '0;
      for (int c = 0; c < CH; c++) begin
        hist[c][e % 64] = 1'b0;
        m_data[c] = '0;
        m_cnt[c] = 0;
        next_wrap[c] = e + G;
        eval_pending[c] = 0;
      end
    end else begin
      if (tx_q.size() > 0) begin
        logic [2*CH-1:0] ent;
        ent = tx_q.pop_front();
        exp_q = ent[CH-1:0];
        exp_t = ent[2*CH-1:CH];
      end else begin
        exp_q = '0;
        exp_t = '1;
      end
      if (accept) begin
        for (int k = 0; k < G; k++) begin
          logic [CH-1:0] eq;
          for (int c = 0; c < CH; c++) eq[c] = tx_data[c*G + k];
          tx_q.push_back({~tx_oe, eq});
        end
      end
      for (int c = 0; c < CH; c++) begin
        hist[c][e % 64] = ser_d[c];
        m_valid[c] = 1'b0;
        if (eval_pending[c] && e == eval_edge[c]) begin
          eval_pending[c] = 0;
          if (train_en) begin
            if (m_data[c] == PAT) begin
              if (m_cnt[c] < LC) m_cnt[c]++;
              m_locked[c] = (m_cnt[c] >= LC);
            end else begin
              m_cnt[c] = 0;
              m_locked[c] = 1'b0;
              next_wrap[c]++;
            end
          end
        end
        if (e == next_wrap[c]) begin
          logic [G-1:0] w;
          for (int j = 0; j < G; j++) w[j] = hist[c][(e - G + j) % 64];
          m_data[c] = w;
          m_valid[c] = 1'b1;
          eval_pending[c] = 1;
          eval_edge[c] = e + 1;
          next_wrap[c] = e + G;
        end
      end
    end
    edge_no++;
  endtask

  // One clock: drive ser_d, check tx_ready, take the edge, update the
  // model and compare all registered outputs.
  task automatic stepCycle();
    logic accept;
    logic [CH*G-1:0] md;
    if (loopback) begin
      ser_d[0] = ser_q[0];
      ser_d[1] = lag1[1];
      lag1 = {lag1[0], ser_q[1]};
      ser_d[2] = ser_q[2] ^ flip2;
      ser_d[3] = ser_q[3];
    end else begin
      ser_d = CH'($urandom);
    end
    if (primed) checkOutput("tx_ready", {63'd0, tx_ready}, {63'd0, (tx_q.size() <= 1)});
    accept = rst_n && tx_valid && (tx_q.size() <= 1);
    @(posedge clk);
    #1;
    modelEdge(accept);
    for (int c = 0; c < CH; c++) md[c*G +: G] = m_data[c];
    checkOutput("ser_q", 64'(ser_q), 64'(exp_q));
    checkOutput("ser_t", 64'(ser_t), 64'(exp_t));
    checkOutput("rx_valid", 64'(rx_valid), 64'(m_valid));
    checkOutput("rx_data", 64'(rx_data), 64'(md));
    checkOutput("rx_locked", 64'(rx_locked), 64'(m_locked));
    primed = 1;
    @(negedge clk);
  endtask

  // Present one word and hold tx_valid until the model says it was taken.
  task automatic applyStimulus(input logic [CH*G-1:0] data, input logic [CH-1:0] oe);
    bit taken;
    taken = 0;
    tx_data = data;
    tx_oe = oe;
    tx_valid = 1'b1;
    for (int i = 0; i < 2*G + 2 && !taken; i++) begin
      taken = (tx_q.size() <= 1);
      stepCycle();
    end
    checkOutput("accept_bound", {63'd0, taken}, 64'd1);
  endtask

  task automatic idle(input int n);
    tx_valid = 1'b0;
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  initial begin
    logic [3:0] w0 [3];
    bit found;
    w0[0] = 4'hA; w0[1] = 4'h5; w0[2] = 4'hC;

    // Reset with random inputs for three edges
    @(negedge clk);
    rst_n = 1'b0;
    train_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_data = CH*G'($urandom);
      tx_oe = CH'($urandom);
      tx_valid = 1'(($urandom));
      stepCycle();
    end
    checkOutput("reset_ser_t", 64'(ser_t), 64'hF);
    checkOutput("reset_ser_q", 64'(ser_q), 64'h0);
    rst_n = 1'b1;
    train_en = 1'b0;
    tx_valid = 1'b0;
    checkOutput("ready_after_reset", {63'd0, tx_ready}, 64'd1);

    // Gapless stream on ch0: A, 5, C with all pins driven
    for (int i = 0; i < 3; i++)
      applyStimulus({12'($urandom), w0[i]}, 4'hF);
    idle(G + 2);

    // Single word then underflow, half the pins tristated
    applyStimulus({12'($urandom), 4'hF}, 4'b0101);
    idle(2*G);

    // Random traffic, random training enable
    for (int i = 0; i < 300; i++) begin
      tx_data = CH*G'($urandom);
      tx_oe = CH'($urandom);
      tx_valid = ($urandom_range(0, 3) != 0);
      train_en = 1'($urandom);
      stepCycle();
    end

    // Loopback training with a two-bit skew on ch1
    rst_n = 1'b0;
    tx_valid = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    loopback = 1;
    lag1 = '0;
    train_en = 1'b1;
    tx_data = 16'h4444;
    tx_oe = 4'hF;
    tx_valid = 1'b1;
    for (int i = 0; i < 200; i++) stepCycle();
    checkOutput("train_locked", 64'(rx_locked), 64'hF);
    checkOutput("train_data", 64'(rx_data), 64'h4444);

    // One corrupted bit on ch2
    flip2 = 1'b1;
    stepCycle();
    flip2 = 1'b0;
    for (int i = 0; i < 160; i++) stepCycle();
    checkOutput("relock", 64'(rx_locked), 64'hF);
    checkOutput("relock_data", 64'(rx_data), 64'h4444);

    // Reset at TX phase 2 while locked, then idle pins
    found = 0;
    for (int i = 0; i < 2*G && !found; i++) begin
      if (tx_q.size() == G - 2) found = 1;
      else stepCycle();
    end
    checkOutput("phase2_bound", {63'd0, found}, 64'd1);
    rst_n = 1'b0;
    stepCycle();
    checkOutput("midreset_locked", 64'(rx_locked), 64'h0);
    checkOutput("midreset_ser_t", 64'(ser_t), 64'hF);
    rst_n = 1'b1;
    tx_valid = 1'b0;
    loopback = 0;
    train_en = 1'b0;
    idle(3*G);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
